// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: PC, single-outstanding imem
// request FSM and the IF/ID instruction register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  input  logic        IdReady,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  output logic [31:0] InstrPcPlus4
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        can_issue;
  logic        req;

  // Issue only into an empty or draining output register.
  assign can_issue = !valid_q || IdReady;
  assign req = (state_q == S_FETCH) && can_issue && !Redirect;

  assign ImemReq      = req;
  assign ImemAddr     = pc_q;
  assign InstrValid   = valid_q;
  assign Instr        = instr_q;
  assign InstrPc      = ipc_q;
  assign InstrPcPlus4 = ipc_q + 32'd4;

  // Next state, PC and output register; redirect overrides all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    if (valid_q && IdReady) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (req && ImemGnt) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ImemRvalid) begin
          valid_d = 1'b1;
          instr_d = ImemRdata;
          ipc_d   = pc_q - 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (ImemRvalid) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (Redirect) begin
      pc_d    = {RedirectPc[31:2], 2'b00};
      valid_d = 1'b0;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      if (state_q == S_FETCH || ImemRvalid) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_DROP;
      end
    end
  end

  // State, PC and IF/ID register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch, stall, redirect,
// PC wrap and asynchronous reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        IdReady;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic [31:0] InstrPcPlus4;

  int n_checks = 0;
  int n_fail = 0;

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemGnt     (ImemGnt),
    .ImemRvalid  (ImemRvalid),
    .ImemRdata   (ImemRdata),
    .Redirect    (Redirect),
    .RedirectPc  (RedirectPc),
    .IdReady     (IdReady),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrPc     (InstrPc),
    .InstrPcPlus4(InstrPcPlus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset      = 1'b0;
    ImemGnt    = 1'b0;
    ImemRvalid = 1'b0;
    ImemRdata  = 32'h0;
    Redirect   = 1'b0;
    RedirectPc = 32'h0;
    IdReady    = 1'b0;
    #12;
    chk("rst_valid", {31'h0, InstrValid}, 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_pc", InstrPc, 32'h0);
    chk("rst_addr", ImemAddr, 32'h0);

    // first fetch, 1-cycle latency
    step();
    reset   = 1'b1;
    ImemGnt = 1'b1;
    settle();
    chk("t1_req", {31'h0, ImemReq}, 32'h1);
    chk("t1_addr", ImemAddr, 32'h0);
    step();
    ImemGnt    = 1'b0;
    ImemRvalid = 1'b1;
    ImemRdata  = 32'h0050_0093;
    settle();
    chk("t1_wait_req", {31'h0, ImemReq}, 32'h0);
    step();
    ImemRvalid = 1'b0;
    settle();
    chk("t1_valid", {31'h0, InstrValid}, 32'h1);
    chk("t1_instr", Instr, 32'h0050_0093);
    chk("t1_ipc", InstrPc, 32'h0);
    chk("t1_pc4", InstrPcPlus4, 32'h4);
    chk("t1_next_addr", ImemAddr, 32'h4);
    chk("t1_stall_req", {31'h0, ImemReq}, 32'h0);

    // decode stall
    for (int i = 0; i < 5; i++) begin
      step();
      settle();
      chk("t2_hold_instr", Instr, 32'h0050_0093);
      chk("t2_hold_pc", InstrPc, 32'h0);
      chk("t2_hold_req", {31'h0, ImemReq}, 32'h0);
    end
    step();
    IdReady = 1'b1;
    ImemGnt = 1'b1;
    settle();
    chk("t2_rel_req", {31'h0, ImemReq}, 32'h1);
    chk("t2_rel_addr", ImemAddr, 32'h4);

    // redirect while WAIT, response 2 cycles later
    step();
    IdReady    = 1'b0;
    ImemGnt    = 1'b0;
    Redirect   = 1'b1;
    RedirectPc = 32'h0000_0103;
    settle();
    chk("t3_redir_req", {31'h0, ImemReq}, 32'h0);
    step();
    Redirect = 1'b0;
    settle();
    chk("t3_drop_addr", ImemAddr, 32'h100);
    chk("t3_drop_req", {31'h0, ImemReq}, 32'h0);
    chk("t3_drop_valid", {31'h0, InstrValid}, 32'h0);
    step();
    ImemRvalid = 1'b1;
    ImemRdata  = 32'hDEAD_BEEF;
    settle();
    chk("t3_rv_req", {31'h0, ImemReq}, 32'h0);
    step();
    ImemRvalid = 1'b0;
    settle();
    chk("t3_valid", {31'h0, InstrValid}, 32'h0);
    chk("t3_req", {31'h0, ImemReq}, 32'h1);
    chk("t3_addr", ImemAddr, 32'h100);

    // redirect coincident with rvalid
    ImemGnt = 1'b1;
    step();
    ImemGnt    = 1'b0;
    ImemRvalid = 1'b1;
    ImemRdata  = 32'h1111_1111;
    Redirect   = 1'b1;
    RedirectPc = 32'h0000_0200;
    step();
    ImemRvalid = 1'b0;
    Redirect   = 1'b0;
    settle();
    chk("t4_valid", {31'h0, InstrValid}, 32'h0);
    chk("t4_req", {31'h0, ImemReq}, 32'h1);
    chk("t4_addr", ImemAddr, 32'h200);

    // PC wrap
    Redirect   = 1'b1;
    RedirectPc = 32'hFFFF_FFFC;
    settle();
    chk("t5_redir_req", {31'h0, ImemReq}, 32'h0);
    step();
    Redirect = 1'b0;
    ImemGnt  = 1'b1;
    settle();
    chk("t5_addr0", ImemAddr, 32'hFFFF_FFFC);
    chk("t5_req0", {31'h0, ImemReq}, 32'h1);
    step();
    ImemGnt    = 1'b0;
    ImemRvalid = 1'b1;
    ImemRdata  = 32'h0010_0113;
    step();
    ImemRvalid = 1'b0;
    IdReady    = 1'b1;
    ImemGnt    = 1'b1;
    settle();
    chk("t5_valid0", {31'h0, InstrValid}, 32'h1);
    chk("t5_instr0", Instr, 32'h0010_0113);
    chk("t5_ipc0", InstrPc, 32'hFFFF_FFFC);
    chk("t5_pc4_0", InstrPcPlus4, 32'h0);
    chk("t5_addr1", ImemAddr, 32'h0);
    chk("t5_req1", {31'h0, ImemReq}, 32'h1);
    step();
    IdReady    = 1'b0;
    ImemGnt    = 1'b0;
    ImemRvalid = 1'b1;
    ImemRdata  = 32'h0020_0193;
    step();
    ImemRvalid = 1'b0;
    settle();
    chk("t5_instr1", Instr, 32'h0020_0193);
    chk("t5_ipc1", InstrPc, 32'h0);
    chk("t5_pc4_1", InstrPcPlus4, 32'h4);

    // async reset mid-WAIT
    IdReady = 1'b1;
    ImemGnt = 1'b1;
    settle();
    chk("t6_req", {31'h0, ImemReq}, 32'h1);
    chk("t6_addr", ImemAddr, 32'h4);
    step();
    IdReady = 1'b0;
    ImemGnt = 1'b0;
    settle();
    chk("t6_wait_addr", ImemAddr, 32'h8);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, InstrValid}, 32'h0);
    chk("t6_rst_instr", Instr, 32'h0000_0013);
    chk("t6_rst_ipc", InstrPc, 32'h0);
    chk("t6_rst_addr", ImemAddr, 32'h0);
    step();
    reset = 1'b1;
    settle();
    chk("t6_post_req", {31'h0, ImemReq}, 32'h1);
    chk("t6_post_addr", ImemAddr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core: holds the program counter, issues one word-aligned fetch at a time to instruction memory and registers the returned word with its PC in an IF/ID output register. The registered `Instr` is the instruction word the immediate generator and decoder consume. Supports back-pressure from decode and PC redirects from branch/jump resolution, including squashing an in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ImemReq`  out  1  fetch request valid.
- `ImemAddr`  out  32  fetch address, equal to the internal PC.
- `ImemGnt`  in  1  memory accepts the request this cycle (only meaningful with `ImemReq`).
- `ImemRvalid`  in  1  read data valid; arrives at least 1 cycle after the grant.
- `ImemRdata`  in  32  fetched instruction word.
- `Redirect`  in  1  load a new PC, discarding all older fetches.
- `RedirectPc`  in  32  target PC; bits [1:0] are ignored and forced to 0.
- `IdReady`  in  1  decode consumes `Instr` this cycle.
- `InstrValid`  out  1  output register holds a valid instruction.
- `Instr`  out  32  instruction word.
- `InstrPc`  out  32  PC of `Instr`.
- `InstrPcPlus4`  out  32  `InstrPc + 4`, mod 2^32.

## Operation
- The internal PC, the FSM state and the output register (`InstrValid`, `Instr`, `InstrPc`) are registered.
- States:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- At most one request is outstanding at any time.
- Issue condition: `CanIssue = !InstrValid || IdReady`.
- `ImemReq = (state==FETCH) && CanIssue && !Redirect`. `ImemAddr = PC` at all times.
- FETCH:
  - on `ImemReq && ImemGnt`: PC <= PC+4 (wraps 0xFFFF_FFFC to 0) and go to WAIT.
  - otherwise stay in FETCH.
- WAIT:
  - on `ImemRvalid`: capture `InstrValid<=1`, `Instr<=ImemRdata`, `InstrPc<=PC-4`, then go to FETCH.
  - The output register is guaranteed empty at capture, because issue required it to be empty or consumed.
- DROP: on `ImemRvalid`, discard the data and go to FETCH. `ImemReq` stays 0 while in DROP.
- Consume: `InstrValid && IdReady` with no capture that cycle gives `InstrValid<=0`.
- Redirect has the highest priority in every state:
  - PC <= {RedirectPc[31:2],2'b00} and `InstrValid<=0`.
  - Next state:
    - FETCH goes to FETCH (no request was issued, since `ImemReq` is suppressed).
    - WAIT without `ImemRvalid` goes to DROP.
    - WAIT or DROP with `ImemRvalid` in the same cycle discards the response and goes to FETCH.
    - DROP without `ImemRvalid` stays in DROP.
- Hold: while `InstrValid && !IdReady`, `Instr` and `InstrPc` do not change.
- A redirect while decode is stalled drops the held instruction.
- Reset, asynchronous and usable mid-operation:
  - PC=`RESET_PC`, state=FETCH.
  - `InstrValid`=0, `Instr`=32'h0000_0013 (NOP), `InstrPc`=0.
  - Any outstanding memory response after reset release must not arrive; the memory is reset by the same signal.

## Timing
- `ImemReq`/`ImemAddr` are combinational from state, PC, `InstrValid`, `IdReady` and `Redirect`.
- Grant in cycle t, `ImemRvalid` in cycle t+k (k≥1) gives `InstrValid`=1 from cycle t+k+1.
- The earliest next request is cycle t+k+1, if `CanIssue`.
- Best-case throughput with k=1: one instruction every 2 cycles.
- Redirect in cycle t gives `ImemAddr`=new PC in t+1; with state FETCH and `CanIssue`, `ImemReq`=1 in t+1.
- After reset release: `ImemReq`=1 and `ImemAddr`=`RESET_PC` in the first cycle.

## Test plan
- Reset, then grant immediately and return 0x00500093 after 1 cycle → `InstrValid`=1, `Instr`=0x00500093, `InstrPc`=0, `InstrPcPlus4`=4. The next request has `ImemAddr`=4.
- Hold `IdReady`=0 for 5 cycles with `Instr` valid → `Instr`/`InstrPc` stable, `ImemReq`=0. Raising `IdReady` gives `ImemReq`=1 in the same cycle.
- Redirect to 0x103 while in WAIT; the response arrives 2 cycles later → data discarded, `InstrValid` stays 0. The next fetch is at 0x100.
- Redirect in the same cycle as `ImemRvalid` → response discarded, FSM in FETCH, `ImemAddr`=RedirectPc in the next cycle, no DROP state entered.
- Redirect to 0xFFFF_FFFC, then two fetches → `InstrPc` values 0xFFFF_FFFC, then 0x0. `InstrPcPlus4` of the first is 0x0.
- Assert reset mid-WAIT → all outputs return to reset values immediately; after release the first `ImemAddr`=`RESET_PC`.
